debug_uart_rx: RTL

Receives the calibration/debug telemetry frame over a UART line (8N1, LSB first, baud = clk/DIV) and decodes it into registered fields. The frame is 33 bytes: 0xBE, 0xEF, mfg, dev, serial (4 B, MSB first), jack, touch0..7, then adc0..adc3 (WM/8 bytes each, MSB first, sign-extended). The block sits on the host/bring-up side of the link, e.g. in loopback test designs or on a second board, so streamed calibration data can be checked in hardware.

---
 rtl/debug_uart_pkg.sv | 31 +++
 rtl/debug_uart_rx_if.sv | 27 ++
 rtl/debug_uart_rx_uart_rx.sv | 85 ++++++++
 rtl/debug_uart_rx.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/debug_uart_pkg.sv
// Shared constants and state types for the debug telemetry UART receiver.
// DEBUG_UART_RX_CHECKSUM_EN adds the CHECK parser state for the trailing XOR byte.
package debug_uart_pkg;

  localparam logic [7:0] MAGIC1 = 8'hBE;
  localparam logic [7:0] MAGIC2 = 8'hEF;

  localparam int FRAME_LEN  = 33;
  localparam int MFG_OFS    = 2;
  localparam int DEV_OFS    = 3;
  localparam int SERIAL_OFS = 4;
  localparam int JACK_OFS   = 8;
  localparam int TOUCH_OFS  = 9;
  localparam int ADC0_OFS   = 17;
  localparam int ADC_STRIDE = 4;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_IDLE
  } rx_state_t;

`ifdef DEBUG_UART_RX_CHECKSUM_EN
  typedef enum logic [1:0] {HUNT1, HUNT2, BODY, CHECK} parser_state_t;
`else
  typedef enum logic [1:0] {HUNT1, HUNT2, BODY} parser_state_t;
`endif

endpackage

// File: rtl/debug_uart_rx_if.sv
// Decoded telemetry fields presented by debug_uart_rx; master = decoder, slave = consumer.
interface debug_uart_rx_if #(
  parameter int W = 16
);
  logic [7:0]          eeprom_mfg;
  logic [7:0]          eeprom_dev;
  logic [31:0]         eeprom_serial;
  logic [7:0]          jack;
  logic [63:0]         touch;
  logic signed [W-1:0] adc0;
  logic signed [W-1:0] adc1;
  logic signed [W-1:0] adc2;
  logic signed [W-1:0] adc3;
  logic                frame_valid;
  logic [7:0]          err_count;
  logic                busy;

  modport master (
    output eeprom_mfg, eeprom_dev, eeprom_serial, jack, touch,
           adc0, adc1, adc2, adc3, frame_valid, err_count, busy
  );

  modport slave (
    input eeprom_mfg, eeprom_dev, eeprom_serial, jack, touch,
          adc0, adc1, adc2, adc3, frame_valid, err_count, busy
  );
endinterface

// File: rtl/debug_uart_rx_uart_rx.sv
// 8N1 byte receiver: 2-flop synchronizer, mid-bit sampling at DIV clocks per bit.
module uart_rx
  import debug_uart_pkg::*;
#(
  parameter int DIV = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err
);

  localparam int CW = $clog2(DIV);

  logic      rx_m, rx_s, rx_d;
  rx_state_t state, state_d;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic          tick, shift_en, valid_d, ferr_d;

  // Start is checked at half a bit, every later sample one full bit apart.
  assign tick = (state == RX_START) ? (cnt == CW'(DIV / 2 - 1)) : (cnt == CW'(DIV - 1));

  // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m      <= 1'b1;
      rx_s      <= 1'b1;
      rx_d      <= 1'b1;
      state     <= RX_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_m      <= rx_i;
      rx_s      <= rx_m;
      rx_d      <= rx_s;
      state     <= state_d;
      cnt       <= (tick || state == RX_IDLE || state == RX_WAIT_IDLE) ? '0 : cnt + 1'b1;
      valid     <= valid_d;
      frame_err <= ferr_d;
      if (state == RX_START) bit_idx <= '0;
      if (shift_en) begin
        data    <= {rx_s, data[7:1]};
        bit_idx <= bit_idx + 1'b1;
      end
    end
  end

  // NOTE: every output of this block is defaulted first so no path leaves a latch behind.
  always_comb begin
    state_d  = state;
    shift_en = 1'b0;
    valid_d  = 1'b0;
    ferr_d   = 1'b0;
    unique case (state)
      RX_IDLE:  if (rx_d && !rx_s) state_d = RX_START;
      RX_START: if (tick) state_d = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA: begin
        if (tick) begin
          shift_en = 1'b1;
          if (bit_idx == 3'd7) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (tick) begin
          if (rx_s) begin
            valid_d = 1'b1;
            state_d = RX_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = RX_WAIT_IDLE;
          end
        end
      end
      RX_WAIT_IDLE: if (rx_s) state_d = RX_IDLE;
      default:      state_d = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/debug_uart_rx.sv
// Telemetry frame parser: hunts BE EF, shadows the body, range-checks ADCs, commits atomically.
// Optional trailing XOR checksum byte when DEBUG_UART_RX_CHECKSUM_EN is defined.
module debug_uart_rx
  import debug_uart_pkg::*;
#(
  parameter int W   = 16,
  parameter int WM  = 32,
  parameter int DIV = 12
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rx_i,
  debug_uart_rx_if.master tel
);

  logic [7:0] rx_data;
  logic       rx_valid, rx_ferr;

  uart_rx #(.DIV(DIV)) u_rx (
    .clk       (clk),
    .rst       (rst),
    .rx_i      (rx_i),
    .data      (rx_data),
    .valid     (rx_valid),
    .frame_err (rx_ferr)
  );

  parser_state_t pstate, pstate_d;
  logic [5:0]    idx, idx_d;
  logic          wr, commit, reject, range_ok;
  logic [7:0]    shadow  [FRAME_LEN];
  logic [7:0]    frame_b [FRAME_LEN];
  logic [WM-1:0] adc_f   [4];

  assign wr       = (pstate == BODY) && rx_valid;
  assign tel.busy = (pstate != HUNT1);

  function automatic logic in_range(input logic [WM-1:0] f);
    return f[WM-1:W-1] == {(WM - W + 1){f[W-1]}};
  endfunction

  // NOTE: shadow bytes 2..32 are all rewritten before any commit, so this storage carries no reset.
  always_ff @(posedge clk) begin
    if (wr) shadow[idx] <= rx_data;
  end

  // Frame as it will look after this cycle's write, so the last byte can commit without a bubble.
  always_comb begin
    for (int i = 0; i < FRAME_LEN; i++) frame_b[i] = shadow[i];
    if (wr) frame_b[idx] = rx_data;
    for (int k = 0; k < 4; k++) begin
      adc_f[k] = {frame_b[ADC0_OFS + ADC_STRIDE * k],     frame_b[ADC0_OFS + ADC_STRIDE * k + 1],
                  frame_b[ADC0_OFS + ADC_STRIDE * k + 2], frame_b[ADC0_OFS + ADC_STRIDE * k + 3]};
    end
    range_ok = in_range(adc_f[0]) && in_range(adc_f[1]) && in_range(adc_f[2]) && in_range(adc_f[3]);
  end

`ifdef DEBUG_UART_RX_CHECKSUM_EN
  logic [7:0] csum;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                           csum <= '0;
    else if (pstate == HUNT2 && rx_valid && rx_data == MAGIC2) csum <= '0;
    else if (wr)                                       csum <= csum ^ rx_data;
  end
`endif

  always_comb begin
    pstate_d = pstate;
    idx_d    = idx;
    commit   = 1'b0;
    reject   = 1'b0;
    unique case (pstate)
      HUNT1: if (rx_valid && rx_data == MAGIC1) pstate_d = HUNT2;
      HUNT2: begin
        if (rx_ferr) pstate_d = HUNT1;
        else if (rx_valid) begin
          if (rx_data == MAGIC2) begin
            pstate_d = BODY;
            idx_d    = 6'd2;
          end else if (rx_data != MAGIC1) begin
            pstate_d = HUNT1;
          end
        end
      end
      BODY: begin
        if (rx_ferr) begin
          reject   = 1'b1;
          pstate_d = HUNT1;
        end else if (rx_valid) begin
          idx_d = idx + 1'b1;
          if (idx == 6'(FRAME_LEN - 1)) begin
`ifdef DEBUG_UART_RX_CHECKSUM_EN
            pstate_d = CHECK;
`else
            commit   = range_ok;
            reject   = !range_ok;
            pstate_d = HUNT1;
`endif
          end
        end
      end
`ifdef DEBUG_UART_RX_CHECKSUM_EN
      CHECK: begin
        if (rx_ferr) begin
          reject   = 1'b1;
          pstate_d = HUNT1;
        end else if (rx_valid) begin
          commit   = range_ok && (rx_data == csum);
          reject   = !commit;
          pstate_d = HUNT1;
        end
      end
`endif
      default: pstate_d = HUNT1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pstate            <= HUNT1;
      idx               <= '0;
      tel.eeprom_mfg    <= '0;
      tel.eeprom_dev    <= '0;
      tel.eeprom_serial <= '0;
      tel.jack          <= '0;
      tel.touch         <= '0;
      tel.adc0          <= '0;
      tel.adc1          <= '0;
      tel.adc2          <= '0;
      tel.adc3          <= '0;
      tel.frame_valid   <= 1'b0;
      tel.err_count     <= '0;
    end else begin
      pstate          <= pstate_d;
      idx             <= idx_d;
      tel.frame_valid <= commit;
      if (reject && tel.err_count != 8'hFF) tel.err_count <= tel.err_count + 1'b1;
      if (commit) begin
        tel.eeprom_mfg    <= frame_b[MFG_OFS];
        tel.eeprom_dev    <= frame_b[DEV_OFS];
        tel.eeprom_serial <= {frame_b[SERIAL_OFS], frame_b[SERIAL_OFS + 1],
                              frame_b[SERIAL_OFS + 2], frame_b[SERIAL_OFS + 3]};
        tel.jack          <= frame_b[JACK_OFS];
        for (int i = 0; i < 8; i++) tel.touch[8*i +: 8] <= frame_b[TOUCH_OFS + i];
        tel.adc0 <= adc_f[0][W-1:0];
        tel.adc1 <= adc_f[1][W-1:0];
        tel.adc2 <= adc_f[2][W-1:0];
        tel.adc3 <= adc_f[3][W-1:0];
      end
    end
  end

endmodule
